// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types and constants for the unified-memory arbiter:
//               FSM state encodings, owner IDs and the grant-priority helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

   // Arbiter sequencer states
   typedef enum logic [1:0] {
      MA_IDLE   = 2'd0,
      MA_BUSY_I = 2'd1,
      MA_BUSY_D = 2'd2,
      MA_RESP   = 2'd3
   } ma_state_e;

   // Owner IDs of the transaction currently on the memory side
   localparam logic MA_OWNER_IF = 1'b0;
   localparam logic MA_OWNER_D  = 1'b1;

   // Data wins a simultaneous request unless it has used up its burst allowance
   function automatic logic ma_pick_data(input logic d_req,
                                         input logic if_req,
                                         input logic burst_at_max);
      return d_req & (~if_req | ~burst_at_max);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ma_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : ma_watchdog
// Description : Loadable cycle counter with clear and enable. expire_o is
//               high while enabled in the cycle the count reaches LIMIT-1,
//               i.e. on the LIMIT-th enabled edge after a clear.
// Revision    : 1.0 - initial release
// ============================================================================
module ma_watchdog #(
   parameter int unsigned LIMIT = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         clr_i,
   input  logic                         en_i,
   input  logic                         load_i,
   input  logic [$clog2(LIMIT+1)-1:0]   load_val_i,
   output logic                         expire_o
);

   localparam int unsigned CW = $clog2(LIMIT + 1);
   localparam logic [CW-1:0] c_last = CW'(LIMIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear wins over load, load over count; holds at the last value
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != c_last)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i & (cnt_q == c_last);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port memory between instruction fetch and
//               data access. One transaction at a time, variable-latency ack,
//               abort on timeout, data priority bounded by a burst allowance.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned DWIDTH         = 32,
   parameter int unsigned AWIDTH_MEM     = 32,
   parameter int unsigned TIMEOUT        = 16,
   parameter int unsigned DATA_BURST_MAX = 4
) (
   input  logic                  ma_clk,
   input  logic                  ma_rst,
   input  logic                  ma_i_if_req,
   input  logic [AWIDTH_MEM-1:0] ma_i_if_addr,
   output logic                  ma_o_if_ack,
   output logic [DWIDTH-1:0]     ma_o_if_rdata,
   output logic                  ma_o_if_err,
   output logic                  ma_o_if_stall,
   input  logic                  ma_i_d_req,
   input  logic                  ma_i_d_we,
   input  logic [AWIDTH_MEM-1:0] ma_i_d_addr,
   input  logic [DWIDTH-1:0]     ma_i_d_wdata,
   output logic                  ma_o_d_ack,
   output logic [DWIDTH-1:0]     ma_o_d_rdata,
   output logic                  ma_o_d_err,
   output logic                  ma_o_d_stall,
   output logic                  ma_o_m_req,
   output logic                  ma_o_m_we,
   output logic [AWIDTH_MEM-1:0] ma_o_m_addr,
   output logic [DWIDTH-1:0]     ma_o_m_wdata,
   input  logic [DWIDTH-1:0]     ma_i_m_rdata,
   input  logic                  ma_i_m_ack
);

   localparam int unsigned BW = $clog2(DATA_BURST_MAX + 1);
   localparam int unsigned WW = $clog2(TIMEOUT + 1);
   localparam logic [BW-1:0] c_burst_max = BW'(DATA_BURST_MAX);

   ma_state_e             state_q;
   logic [BW-1:0]         burst_cnt_q;
   logic [BW-1:0]         burst_cnt_d;
   logic                  m_req_q;
   logic                  m_we_q;
   logic [AWIDTH_MEM-1:0] m_addr_q;
   logic [DWIDTH-1:0]     m_wdata_q;
   logic                  if_ack_q;
   logic                  if_err_q;
   logic [DWIDTH-1:0]     if_rdata_q;
   logic                  d_ack_q;
   logic                  d_err_q;
   logic [DWIDTH-1:0]     d_rdata_q;

   logic                  w_grant_d;
   logic                  w_grant_i;
   logic                  w_busy;
   logic                  w_expire;
   logic                  w_done;
   logic                  w_owner;
   logic [DWIDTH-1:0]     w_resp_rdata;

   // Arbitration decision, only meaningful in IDLE
   always_comb begin
      w_grant_d = 1'b0;
      w_grant_i = 1'b0;
      if (state_q == MA_IDLE) begin
         if (ma_pick_data(ma_i_d_req, ma_i_if_req, burst_cnt_q == c_burst_max)) begin
            w_grant_d = 1'b1;
         end else if (ma_i_if_req) begin
            w_grant_i = 1'b1;
         end
      end
   end

   assign w_busy       = (state_q == MA_BUSY_I) || (state_q == MA_BUSY_D);
   assign w_done       = w_busy && (ma_i_m_ack || w_expire);
   assign w_owner      = (state_q == MA_BUSY_D) ? MA_OWNER_D : MA_OWNER_IF;
   // Writes and aborted accesses return zero
   assign w_resp_rdata = (ma_i_m_ack && !m_we_q) ? ma_i_m_rdata : '0;

   // Fairness counter: data grants that overtook a waiting fetch
   always_comb begin
      burst_cnt_d = burst_cnt_q;
      if (w_grant_i) begin
         burst_cnt_d = '0;
      end else if ((state_q == MA_IDLE) && !ma_i_if_req) begin
         burst_cnt_d = '0;
      end else if (w_grant_d && ma_i_if_req && (burst_cnt_q != c_burst_max)) begin
         burst_cnt_d = burst_cnt_q + 1'b1;
      end
   end

   // Fairness counter register
   always_ff @(posedge ma_clk or negedge ma_rst) begin
      if (!ma_rst) begin
         burst_cnt_q <= '0;
      end else begin
         burst_cnt_q <= burst_cnt_d;
      end
   end

   // Wait counter: cleared on grant, counts BUSY edges without ack
   ma_watchdog #(
      .LIMIT (TIMEOUT)
   ) u_watchdog (
      .clk_i      (ma_clk),
      .rst_ni     (ma_rst),
      .clr_i      (w_grant_d | w_grant_i),
      .en_i       (w_busy & ~ma_i_m_ack),
      .load_i     (1'b0),
      .load_val_i ({WW{1'b0}}),
      .expire_o   (w_expire)
   );

   // Sequencer FSM with registered memory-side and response outputs
   always_ff @(posedge ma_clk or negedge ma_rst) begin
      if (!ma_rst) begin
         state_q    <= MA_IDLE;
         m_req_q    <= 1'b0;
         m_we_q     <= 1'b0;
         m_addr_q   <= '0;
         m_wdata_q  <= '0;
         if_ack_q   <= 1'b0;
         if_err_q   <= 1'b0;
         if_rdata_q <= '0;
         d_ack_q    <= 1'b0;
         d_err_q    <= 1'b0;
         d_rdata_q  <= '0;
      end else begin
         if_ack_q <= 1'b0;
         if_err_q <= 1'b0;
         d_ack_q  <= 1'b0;
         d_err_q  <= 1'b0;
         case (state_q)
            MA_IDLE: begin
               if (w_grant_d) begin
                  state_q   <= MA_BUSY_D;
                  m_req_q   <= 1'b1;
                  m_we_q    <= ma_i_d_we;
                  m_addr_q  <= ma_i_d_addr;
                  m_wdata_q <= ma_i_d_wdata;
               end else if (w_grant_i) begin
                  state_q   <= MA_BUSY_I;
                  m_req_q   <= 1'b1;
                  m_we_q    <= 1'b0;
                  m_addr_q  <= ma_i_if_addr;
                  m_wdata_q <= '0;
               end
            end
            MA_BUSY_I, MA_BUSY_D: begin
               if (w_done) begin
                  state_q <= MA_RESP;
                  m_req_q <= 1'b0;
                  if (w_owner == MA_OWNER_D) begin
                     d_ack_q   <= 1'b1;
                     d_err_q   <= ~ma_i_m_ack;
                     d_rdata_q <= w_resp_rdata;
                  end else begin
                     if_ack_q   <= 1'b1;
                     if_err_q   <= ~ma_i_m_ack;
                     if_rdata_q <= w_resp_rdata;
                  end
               end
            end
            MA_RESP: begin
               state_q <= MA_IDLE;
            end
            default: begin
               state_q <= MA_IDLE;
            end
         endcase
      end
   end

   assign ma_o_m_req    = m_req_q;
   assign ma_o_m_we     = m_we_q;
   assign ma_o_m_addr   = m_addr_q;
   assign ma_o_m_wdata  = m_wdata_q;
   assign ma_o_if_ack   = if_ack_q;
   assign ma_o_if_err   = if_err_q;
   assign ma_o_if_rdata = if_rdata_q;
   assign ma_o_d_ack    = d_ack_q;
   assign ma_o_d_err    = d_err_q;
   assign ma_o_d_rdata  = d_rdata_q;
   assign ma_o_if_stall = ma_i_if_req & ~if_ack_q;
   assign ma_o_d_stall  = ma_i_d_req & ~d_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: port agents, a memory
//               responder with per-request latency, and a transaction-level
//               model of grant order and response contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   localparam int TO   = 16;
   localparam int BMAX = 4;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      int          lat;     // 0 = memory never acks
   } req_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      int          cyc;
   } grant_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req, if_ack, if_err, if_stall;
   logic [31:0] if_addr, if_rdata;
   logic        d_req, d_we, d_ack, d_err, d_stall;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        m_req, m_we, m_ack;
   logic [31:0] m_addr, m_wdata, m_rdata;

   req_t   if_q[$], d_q[$], bi[$], bd[$];
   rsp_t   if_rsp[$], d_rsp[$];
   grant_t glog[$];
   int     dur_log[$];
   bit     exp_own[$];
   logic [31:0] tbmem [logic [31:0]];
   logic [31:0] model_mem [logic [31:0]];

   int checks = 0, failures = 0, cyc = 0;
   int if_ack_cnt = 0, d_ack_cnt = 0, stall_bad = 0, stab_bad = 0;
   int cur_if_lat = 0, cur_d_lat = 0;
   logic [31:0] cur_d_addr = '0;
   logic stray_ack = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_arbiter #(
      .DWIDTH(32), .AWIDTH_MEM(32), .TIMEOUT(TO), .DATA_BURST_MAX(BMAX)
   ) dut (
      .ma_clk(clk), .ma_rst(rst_n),
      .ma_i_if_req(if_req), .ma_i_if_addr(if_addr), .ma_o_if_ack(if_ack),
      .ma_o_if_rdata(if_rdata), .ma_o_if_err(if_err), .ma_o_if_stall(if_stall),
      .ma_i_d_req(d_req), .ma_i_d_we(d_we), .ma_i_d_addr(d_addr),
      .ma_i_d_wdata(d_wdata), .ma_o_d_ack(d_ack), .ma_o_d_rdata(d_rdata),
      .ma_o_d_err(d_err), .ma_o_d_stall(d_stall),
      .ma_o_m_req(m_req), .ma_o_m_we(m_we), .ma_o_m_addr(m_addr),
      .ma_o_m_wdata(m_wdata), .ma_i_m_rdata(m_rdata), .ma_i_m_ack(m_ack)
   );

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   function automatic logic [31:0] exp_fetch(input logic [31:0] a);
      return (a == 32'h40) ? 32'h8C22_0004 : dflt(a);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Grant order from the arbitration rules with both queues kept loaded
   function automatic void model_order(input int ni, input int nd);
      int c;
      c = 0;
      exp_own.delete();
      while (ni > 0 || nd > 0) begin
         if (ni > 0 && nd > 0) begin
            if (c == BMAX) begin exp_own.push_back(1'b0); ni--; c = 0; end
            else begin exp_own.push_back(1'b1); nd--; c++; end
         end else if (nd > 0) begin
            exp_own.push_back(1'b1); nd--; c = 0;
         end else begin
            exp_own.push_back(1'b0); ni--;
         end
      end
   endfunction

   // Fetch agent: present, hold until ack, update at the edge ending RESP
   initial begin
      req_t cur;
      logic done, dropped;
      done = 1'b0;
      if_req = 1'b0; if_addr = '0;
      forever begin
         @(posedge clk); #1;
         dropped = 1'b0;
         if (done) begin if_req = 1'b0; done = 1'b0; dropped = 1'b1; end
         if (if_req) begin
            if (if_ack) begin
               if_rsp.push_back('{if_rdata, if_err});
               if (if_stall !== 1'b0) stall_bad++;
               done = 1'b1;
            end else if (if_stall !== 1'b1) stall_bad++;
         end else if (if_q.size() > 0) begin
            cur = if_q.pop_front();
            if_addr = cur.addr; cur_if_lat = cur.lat; if_req = 1'b1;
         end else if (!dropped && if_stall !== 1'b0) stall_bad++;
      end
   end

   // Data agent
   initial begin
      req_t cur;
      logic done, dropped;
      done = 1'b0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      forever begin
         @(posedge clk); #1;
         dropped = 1'b0;
         if (done) begin d_req = 1'b0; done = 1'b0; dropped = 1'b1; end
         if (d_req) begin
            if (d_ack) begin
               d_rsp.push_back('{d_rdata, d_err});
               if (d_stall !== 1'b0) stall_bad++;
               done = 1'b1;
            end else if (d_stall !== 1'b1) stall_bad++;
         end else if (d_q.size() > 0) begin
            cur = d_q.pop_front();
            d_addr = cur.addr; d_we = cur.we; d_wdata = cur.wdata;
            cur_d_addr = cur.addr; cur_d_lat = cur.lat; d_req = 1'b1;
         end else if (!dropped && d_stall !== 1'b0) stall_bad++;
      end
   end

   // Memory responder: acks after the owning request's latency
   initial begin
      int cnt, lat;
      cnt = 0; lat = 0;
      m_ack = 1'b0; m_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (m_req) begin
            if (cnt == 0) lat = (d_req && m_addr == cur_d_addr) ? cur_d_lat : cur_if_lat;
            cnt++;
            if (lat != 0 && cnt == lat) begin
               m_ack = 1'b1;
               if (m_we) begin tbmem[m_addr] = m_wdata; m_rdata = $urandom; end
               else m_rdata = tbmem.exists(m_addr) ? tbmem[m_addr] : dflt(m_addr);
            end else begin
               m_ack = 1'b0; m_rdata = $urandom;
            end
         end else begin
            cnt = 0; m_ack = stray_ack; m_rdata = 32'h1234_5678;
         end
      end
   end

   // Memory-side monitor: grant log, req durations, stability, ack pulses
   initial begin
      logic prev;
      int d;
      prev = 1'b0; d = 0;
      forever begin
         @(posedge clk); #1;
         if (m_req && !prev) begin glog.push_back('{m_addr, m_we, m_wdata, cyc}); d = 0; end
         if (m_req) begin
            d++;
            if (glog.size() > 0)
               if (m_addr !== glog[glog.size()-1].addr || m_we !== glog[glog.size()-1].we ||
                   m_wdata !== glog[glog.size()-1].wdata) stab_bad++;
         end
         if (!m_req && prev) dur_log.push_back(d);
         if (if_ack) if_ack_cnt++;
         if (d_ack) d_ack_cnt++;
         prev = m_req;
      end
   end

   task automatic wait_rsp(input int ni, input int nd, input int budget, input string tag);
      int n;
      n = 0;
      while ((if_rsp.size() < ni || d_rsp.size() < nd) && n < budget) begin
         @(posedge clk); n++;
      end
      check({tag, "_done"}, 64'(if_rsp.size() >= ni && d_rsp.size() >= nd), 64'd1);
      repeat (3) @(posedge clk);
   endtask

   task automatic run_batch(input string tag);
      int ni, nd, ii, di;
      logic [31:0] ea, er;
      glog.delete(); dur_log.delete(); if_rsp.delete(); d_rsp.delete();
      stall_bad = 0; stab_bad = 0;
      ni = bi.size(); nd = bd.size();
      foreach (bi[k]) if_q.push_back(bi[k]);
      foreach (bd[k]) d_q.push_back(bd[k]);
      wait_rsp(ni, nd, 40 * (ni + nd) + 100, tag);
      model_order(ni, nd);
      check({tag, "_ngrant"}, 64'(glog.size()), 64'(exp_own.size()));
      ii = 0; di = 0;
      foreach (exp_own[k]) begin
         if (exp_own[k]) begin ea = bd[di].addr; di++; end
         else begin ea = bi[ii].addr; ii++; end
         check({tag, "_gaddr"}, (k < glog.size()) ? glog[k].addr : 32'hxxxx_xxxx, ea);
      end
      foreach (bi[k]) begin
         er = (bi[k].lat == 0) ? 32'h0 : exp_fetch(bi[k].addr);
         check({tag, "_if_rdata"}, (k < if_rsp.size()) ? if_rsp[k].rdata : 32'hxxxx_xxxx, er);
         check({tag, "_if_err"}, (k < if_rsp.size()) ? if_rsp[k].err : 1'bx, bi[k].lat == 0);
      end
      foreach (bd[k]) begin
         if (bd[k].lat == 0 || bd[k].we) er = 32'h0;
         else er = model_mem.exists(bd[k].addr) ? model_mem[bd[k].addr] : dflt(bd[k].addr);
         if (bd[k].lat != 0 && bd[k].we) model_mem[bd[k].addr] = bd[k].wdata;
         check({tag, "_d_rdata"}, (k < d_rsp.size()) ? d_rsp[k].rdata : 32'hxxxx_xxxx, er);
         check({tag, "_d_err"}, (k < d_rsp.size()) ? d_rsp[k].err : 1'bx, bd[k].lat == 0);
      end
      check({tag, "_stall"}, 64'(stall_bad), 64'd0);
      check({tag, "_m_stable"}, 64'(stab_bad), 64'd0);
   endtask

   function automatic int rnd_lat();
      return ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 6));
   endfunction

   // Global bound on simulation time
   initial begin
      #2_000_000;
      $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "simulation did not finish");
   end

   initial begin
      int acks0, n, ni, nd;
      tbmem[32'h40] = 32'h8C22_0004;

      // Reset state
      repeat (3) @(posedge clk); #1;
      check("rst_m_req", m_req, 0);       check("rst_m_we", m_we, 0);
      check("rst_m_addr", m_addr, 0);     check("rst_m_wdata", m_wdata, 0);
      check("rst_if_ack", if_ack, 0);     check("rst_d_ack", d_ack, 0);
      check("rst_if_err", if_err, 0);     check("rst_d_err", d_err, 0);
      check("rst_if_rdata", if_rdata, 0); check("rst_d_rdata", d_rdata, 0);
      check("rst_if_stall", if_stall, 0); check("rst_d_stall", d_stall, 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Single fetch, memory acks after 2 cycles
      acks0 = if_ack_cnt;
      bi.delete(); bd.delete();
      bi.push_back('{32'h40, 1'b0, 32'h0, 2});
      run_batch("t1");
      check("t1_mreq_len", (dur_log.size() > 0) ? dur_log[0] : -1, 2);
      check("t1_ack_pulses", if_ack_cnt - acks0, 1);
      check("t1_m_we", (glog.size() > 0) ? glog[0].we : 1'bx, 0);

      // Simultaneous requests: data first, fetch three cycles later
      bi.delete(); bd.delete();
      bi.push_back('{32'h44, 1'b0, 32'h0, 1});
      bd.push_back('{32'h1000_0010, 1'b0, 32'h0, 1});
      run_batch("t2");
      check("t2_gap", (glog.size() > 1) ? glog[1].cyc - glog[0].cyc : -1, 3);

      // Six loads against one pending fetch
      bi.delete(); bd.delete();
      bi.push_back('{32'h48, 1'b0, 32'h0, 1});
      for (int i = 0; i < 6; i++) bd.push_back('{32'h1000_0000 + 32'(i * 4), 1'b0, 32'h0, 1});
      run_batch("t3");

      // Store
      bi.delete(); bd.delete();
      bd.push_back('{32'h100, 1'b1, 32'hDEAD_BEEF, 1});
      run_batch("t4");
      check("t4_m_we", (glog.size() > 0) ? glog[0].we : 1'bx, 1);
      check("t4_m_wdata", (glog.size() > 0) ? glog[0].wdata : 32'hx, 32'hDEAD_BEEF);
      check("t4_mem", tbmem.exists(32'h100) ? tbmem[32'h100] : 32'hx, 32'hDEAD_BEEF);

      // Memory never acks: abort after TIMEOUT cycles, stray ack ignored
      bi.delete(); bd.delete();
      bd.push_back('{32'h1000_0020, 1'b0, 32'h0, 0});
      run_batch("t5");
      check("t5_mreq_len", (dur_log.size() > 0) ? dur_log[0] : -1, TO);
      acks0 = if_ack_cnt + d_ack_cnt;
      stray_ack = 1'b1;
      @(posedge clk); #1;
      stray_ack = 1'b0;
      repeat (4) @(posedge clk); #1;
      check("t5_stray_acks", if_ack_cnt + d_ack_cnt - acks0, 0);
      check("t5_stray_mreq", m_req, 0);
      check("t5_stray_grants", glog.size(), 1);
      check("t5_stray_rdata", d_rdata, 0);

      // Ack on the last allowed cycle still succeeds
      bi.delete(); bd.delete();
      bd.push_back('{32'h1000_0024, 1'b0, 32'h0, TO});
      run_batch("t5b");
      check("t5b_mreq_len", (dur_log.size() > 0) ? dur_log[0] : -1, TO);

      // Asynchronous reset during a data access, then re-grant
      glog.delete(); d_rsp.delete(); stall_bad = 0;
      d_q.push_back('{32'h1000_0030, 1'b0, 32'h0, 6});
      n = 0;
      while (!m_req && n < 20) begin @(posedge clk); #1; n++; end
      check("t6_granted", m_req, 1);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("t6_m_req", m_req, 0);        check("t6_m_addr", m_addr, 0);
      check("t6_m_we", m_we, 0);          check("t6_m_wdata", m_wdata, 0);
      check("t6_acks", {if_ack, d_ack}, 0);
      check("t6_errs", {if_err, d_err}, 0);
      check("t6_if_rdata", if_rdata, 0);  check("t6_d_rdata", d_rdata, 0);
      check("t6_d_stall", d_stall, 1);
      @(posedge clk); #2 rst_n = 1'b1;
      wait_rsp(0, 1, 100, "t6");
      check("t6_regrants", glog.size(), 2);
      check("t6_regrant_addr", (glog.size() > 1) ? glog[1].addr : 32'hx, 32'h1000_0030);
      check("t6_rdata", (d_rsp.size() > 0) ? d_rsp[0].rdata : 32'hx, dflt(32'h1000_0030));
      check("t6_err", (d_rsp.size() > 0) ? d_rsp[0].err : 1'bx, 0);
      check("t6_stall", stall_bad, 0);

      // Randomized mixed traffic
      for (int r = 0; r < 5; r++) begin
         bi.delete(); bd.delete();
         ni = int'($urandom_range(0, 4));
         nd = int'($urandom_range(1, 8));
         for (int i = 0; i < ni; i++)
            bi.push_back('{32'h2000 + ($urandom_range(0, 63) << 2), 1'b0, 32'h0, rnd_lat()});
         for (int i = 0; i < nd; i++)
            bd.push_back('{32'h1000_0000 | ($urandom_range(0, 7) << 2),
                           1'($urandom_range(0, 1)), $urandom, rnd_lat()});
         run_batch("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
